// File: rtl/rf_pkg.sv
// rf_pkg: write-back mode encodings, default sizes and the load-extension helper
package rf_pkg;
    localparam int DW_DEF  = 32;
    localparam int AW_DEF  = 5;
    localparam int PCW_DEF = 2;
    localparam int MAXW    = 64;
    typedef enum logic [2:0] {
        WB_NONE   = 3'd0,
        WB_WORD   = 3'd1,
        WB_HALF_S = 3'd2,
        WB_BYTE_S = 3'd3,
        WB_HALF_U = 3'd4,
        WB_BYTE_U = 3'd5
    } wb_mode_e;
    // Extends to MAXW; callers truncate to their own DW, which keeps the sign fill intact.
    function automatic logic [MAXW-1:0] rf_ext(input logic [2:0] mode, input logic [MAXW-1:0] data);
        return mode == WB_HALF_S ? {{(MAXW-16){data[15]}}, data[15:0]} :
               mode == WB_BYTE_S ? {{(MAXW-8){data[7]}}, data[7:0]} :
               mode == WB_HALF_U ? {{(MAXW-16){1'b0}}, data[15:0]} :
               mode == WB_BYTE_U ? {{(MAXW-8){1'b0}}, data[7:0]} : data;
    endfunction
    function automatic logic rf_mode_wr(input logic [2:0] mode);
        return mode inside {[WB_WORD:WB_BYTE_U]};
    endfunction
endpackage

// File: rtl/rf_sb_counter.sv
// rf_sb_counter: one register's pending-write count; inc and dec together cancel out
module rf_sb_counter #(
    parameter int PCW = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           inc,
    input  logic           dec,
    output logic [PCW-1:0] cnt,
    output logic           full,
    output logic           zero,
    output logic           underflow
);
    assign full      = &cnt;
    assign zero      = cnt == '0;
    assign underflow = dec && !inc && zero;
    always_ff @(posedge clk or negedge rst)
        if (!rst)
            cnt <= '0;
        else if (inc && !dec)
            cnt <= cnt + 1'b1;
        else if (dec && !inc && !zero)
            cnt <= cnt - 1'b1;
endmodule

// File: rtl/rf_scoreboard.sv
// rf_scoreboard: NREAD-port register file with extending write-back, bypass and pending-write scoreboard.
// Define RF_TRACE_EN to print every register write in simulation.
module rf_scoreboard import rf_pkg::*; #(
    parameter int DW    = DW_DEF,
    parameter int AW    = AW_DEF,
    parameter int NREAD = 2,
    parameter int PCW   = PCW_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREAD*AW-1:0] rd_addr,
    output logic [NREAD*DW-1:0] rd_data,
    output logic [NREAD-1:0]  rd_busy,
    input  logic              issue_vld,
    input  logic [AW-1:0]     issue_addr,
    output logic              issue_rdy,
    input  logic              wb_vld,
    input  logic [AW-1:0]     wb_addr,
    input  logic [2:0]        wb_mode,
    input  logic [DW-1:0]     wb_data,
    input  logic [AW-1:0]     reg_sel,
    output logic [DW-1:0]     reg_data,
    output logic              err_underflow
);
    localparam int DEPTH = 1 << AW;
    logic [DW-1:0]    regs [DEPTH];
    logic [PCW-1:0]   cnt  [DEPTH];
    logic [DEPTH-1:0] full, zero, uf;
    logic [DW-1:0]    wr_data;
    logic             wb_act, wr_en, issue_fire;
    assign wb_act     = wb_vld && rf_mode_wr(wb_mode);
    assign wr_en      = wb_act && wb_addr != '0;
    assign wr_data    = DW'(rf_ext(wb_mode, MAXW'(wb_data)));
    assign issue_rdy  = !full[issue_addr];
    assign issue_fire = issue_vld && issue_rdy && issue_addr != '0;
    assign reg_data   = regs[reg_sel];
    assign cnt[0]  = '0;
    assign full[0] = 1'b0;
    assign zero[0] = 1'b1;
    assign uf[0]   = 1'b0;
    for (genvar r = 1; r < DEPTH; r++) begin : g_cnt
        rf_sb_counter #(.PCW(PCW)) u_cnt (
            .clk      (clk),
            .rst      (rst),
            .inc      (issue_fire && issue_addr == AW'(r)),
            .dec      (wb_act && wb_addr == AW'(r)),
            .cnt      (cnt[r]),
            .full     (full[r]),
            .zero     (zero[r]),
            .underflow(uf[r])
        );
    end
    for (genvar i = 0; i < NREAD; i++) begin : g_rd
        logic [AW-1:0] a;
        logic          hit;
        assign a   = rd_addr[i*AW +: AW];
        assign hit = wr_en && wb_addr == a;
        assign rd_data[i*DW +: DW] = a == '0 ? '0 : hit ? wr_data : regs[a];
        // The last outstanding write landing this cycle already satisfies the reader via bypass.
        assign rd_busy[i] = !zero[a] && !(hit && cnt[a] == PCW'(1));
    end
    always_ff @(posedge clk or negedge rst)
        if (!rst)
            err_underflow <= 1'b0;
        else if (|uf)
            err_underflow <= 1'b1;
`ifdef RF_TRACE_EN
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            for (int k = 0; k < DEPTH; k++)
                regs[k] <= '0;
        end else if (wr_en) begin
            regs[wb_addr] <= wr_data;
            $display("r[%2d] = 0x%h", wb_addr, wr_data);
        end
`else
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            for (int k = 0; k < DEPTH; k++)
                regs[k] <= '0;
        end else if (wr_en)
            regs[wb_addr] <= wr_data;
`endif
endmodule

// File: tb/tb_rf_scoreboard.sv
// tb_rf_scoreboard: directed vector table plus hand-written scoreboard, r0, underflow and async-reset sequences
module tb_rf_scoreboard;
    localparam int DW = 32, AW = 5, NREAD = 2, PCW = 2;
    logic clk = 1'b0, rst = 1'b0;
    logic [NREAD*AW-1:0] rd_addr;
    logic [NREAD*DW-1:0] rd_data;
    logic [NREAD-1:0]    rd_busy;
    logic issue_vld, issue_rdy, wb_vld, err_underflow;
    logic [AW-1:0] issue_addr, wb_addr, reg_sel;
    logic [2:0]    wb_mode;
    logic [DW-1:0] wb_data, reg_data;
    int total = 0, bad = 0;

    typedef struct {
        logic [AW-1:0] a0, a1;
        logic          wv;
        logic [AW-1:0] wa;
        logic [2:0]    wm;
        logic [DW-1:0] wd;
        logic          iv;
        logic [AW-1:0] ia, sel;
        logic [DW-1:0] e0, e1;
        logic [1:0]    eb;
        logic          er;
        logic [DW-1:0] eg;
        logic          ee;
    } vec_t;

    rf_scoreboard #(.DW(DW), .AW(AW), .NREAD(NREAD), .PCW(PCW)) dut (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .issue_vld(issue_vld), .issue_addr(issue_addr), .issue_rdy(issue_rdy),
        .wb_vld(wb_vld), .wb_addr(wb_addr), .wb_mode(wb_mode), .wb_data(wb_data),
        .reg_sel(reg_sel), .reg_data(reg_data), .err_underflow(err_underflow)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        rd_addr    = {v.a1, v.a0};
        wb_vld     = v.wv;
        wb_addr    = v.wa;
        wb_mode    = v.wm;
        wb_data    = v.wd;
        issue_vld  = v.iv;
        issue_addr = v.ia;
        reg_sel    = v.sel;
    endtask

    task automatic check(input string nm, input vec_t v);
        cmp({nm, ".rd0"}, rd_data[31:0], v.e0);
        cmp({nm, ".rd1"}, rd_data[63:32], v.e1);
        cmp({nm, ".busy"}, 32'(rd_busy), 32'(v.eb));
        cmp({nm, ".rdy"}, 32'(issue_rdy), 32'(v.er));
        cmp({nm, ".reg"}, reg_data, v.eg);
        cmp({nm, ".err"}, 32'(err_underflow), 32'(v.ee));
    endtask

    task automatic apply(input string nm, input vec_t v);
        @(negedge clk);
        drive(v);
        #1;
        check(nm, v);
    endtask

    vec_t tbl[12];
    vec_t v;

    initial begin
        //            a0 a1 wv wa wm wd             iv ia sel  e0             e1             eb er eg             ee
        tbl[0]  = '{5, 0, 0, 0, 0, 32'h0,          0, 0, 5,  32'h0,         32'h0,         0, 1, 32'h0,         0};
        tbl[1]  = '{5, 3, 1, 5, 1, 32'hDEADBEEF,   1, 5, 5,  32'hDEADBEEF,  32'h0,         0, 1, 32'h0,         0};
        tbl[2]  = '{5, 3, 0, 0, 0, 32'h0,          0, 0, 5,  32'hDEADBEEF,  32'h0,         0, 1, 32'hDEADBEEF,  0};
        tbl[3]  = '{5, 3, 1, 3, 2, 32'h000080F0,   1, 3, 3,  32'hDEADBEEF,  32'hFFFF80F0,  0, 1, 32'h0,         0};
        tbl[4]  = '{5, 3, 1, 3, 3, 32'h000080F0,   1, 3, 3,  32'hDEADBEEF,  32'hFFFFFFF0,  0, 1, 32'hFFFF80F0,  0};
        tbl[5]  = '{5, 3, 1, 3, 4, 32'h000080F0,   1, 3, 3,  32'hDEADBEEF,  32'h000080F0,  0, 1, 32'hFFFFFFF0,  0};
        tbl[6]  = '{5, 3, 1, 3, 5, 32'h000080F0,   1, 3, 3,  32'hDEADBEEF,  32'h000000F0,  0, 1, 32'h000080F0,  0};
        tbl[7]  = '{5, 3, 1, 3, 6, 32'h000080F0,   0, 0, 3,  32'hDEADBEEF,  32'h000000F0,  0, 1, 32'h000000F0,  0};
        tbl[8]  = '{5, 3, 1, 3, 7, 32'h0000FFFF,   0, 0, 3,  32'hDEADBEEF,  32'h000000F0,  0, 1, 32'h000000F0,  0};
        tbl[9]  = '{7, 3, 1, 7, 1, 32'h12345678,   1, 7, 7,  32'h12345678,  32'h000000F0,  0, 1, 32'h0,         0};
        tbl[10] = '{7, 3, 0, 0, 0, 32'h0,          0, 0, 7,  32'h12345678,  32'h000000F0,  0, 1, 32'h12345678,  0};
        tbl[11] = '{7, 3, 1, 7, 0, 32'h55555555,   0, 0, 7,  32'h12345678,  32'h000000F0,  0, 1, 32'h12345678,  0};

        drive('{0, 0, 0, 0, 0, 32'h0, 0, 0, 0, 32'h0, 32'h0, 0, 1, 32'h0, 0});
        repeat (2) @(negedge clk);
        drive('{5, 9, 0, 0, 0, 32'h0, 0, 9, 5, 32'h0, 32'h0, 0, 1, 32'h0, 0});
        #1;
        check("in_reset", '{5, 9, 0, 0, 0, 32'h0, 0, 9, 5, 32'h0, 32'h0, 0, 1, 32'h0, 0});
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 12; i++)
            apply($sformatf("vec%0d", i), tbl[i]);

        // Fill r9's counter to the limit, then drain it.
        apply("sb_iss1", '{9, 0, 0, 0, 0, 32'h0, 1, 9, 9, 32'h0, 32'h0, 0, 1, 32'h0, 0});
        apply("sb_iss2", '{9, 0, 0, 0, 0, 32'h0, 1, 9, 9, 32'h0, 32'h0, 1, 1, 32'h0, 0});
        apply("sb_iss3", '{9, 0, 0, 0, 0, 32'h0, 1, 9, 9, 32'h0, 32'h0, 1, 1, 32'h0, 0});
        apply("sb_full", '{9, 0, 0, 0, 0, 32'h0, 1, 9, 9, 32'h0, 32'h0, 1, 0, 32'h0, 0});
        apply("sb_hold", '{9, 0, 0, 0, 0, 32'h0, 0, 9, 9, 32'h0, 32'h0, 1, 0, 32'h0, 0});
        apply("sb_wb1",  '{9, 0, 1, 9, 1, 32'h99,  0, 9, 9, 32'h99, 32'h0, 1, 0, 32'h0, 0});
        apply("sb_both", '{9, 0, 1, 9, 1, 32'h9A,  1, 9, 9, 32'h9A, 32'h0, 1, 1, 32'h99, 0});
        apply("sb_wb2",  '{9, 0, 1, 9, 1, 32'h9B,  0, 9, 9, 32'h9B, 32'h0, 1, 1, 32'h9A, 0});
        apply("sb_last", '{9, 0, 1, 9, 1, 32'h9C,  0, 9, 9, 32'h9C, 32'h0, 0, 1, 32'h9B, 0});
        apply("sb_idle", '{9, 0, 0, 0, 0, 32'h0,   0, 9, 9, 32'h9C, 32'h0, 0, 1, 32'h9C, 0});

        apply("r0_wr",   '{0, 0, 1, 0, 1, 32'hFFFFFFFF, 1, 0, 0, 32'h0, 32'h0, 0, 1, 32'h0, 0});
        apply("r0_rd",   '{0, 0, 0, 0, 0, 32'h0,        1, 0, 0, 32'h0, 32'h0, 0, 1, 32'h0, 0});

        apply("uf_wb",   '{4, 0, 1, 4, 1, 32'hA5A5A5A5, 0, 0, 4, 32'hA5A5A5A5, 32'h0, 0, 1, 32'h0, 0});
        apply("uf_set",  '{4, 0, 0, 0, 0, 32'h0,        0, 0, 4, 32'hA5A5A5A5, 32'h0, 0, 1, 32'hA5A5A5A5, 1});
        apply("uf_held", '{4, 0, 0, 0, 0, 32'h0,        0, 0, 4, 32'hA5A5A5A5, 32'h0, 0, 1, 32'hA5A5A5A5, 1});

        apply("ar_iss1", '{9, 5, 0, 0, 0, 32'h0, 1, 9, 5, 32'h9C, 32'hDEADBEEF, 0, 1, 32'hDEADBEEF, 1});
        apply("ar_iss2", '{9, 5, 0, 0, 0, 32'h0, 1, 9, 5, 32'h9C, 32'hDEADBEEF, 1, 1, 32'hDEADBEEF, 1});
        // Assert reset between clock edges; state must clear without a posedge.
        v = '{9, 5, 0, 0, 0, 32'h0, 0, 9, 5, 32'h9C, 32'hDEADBEEF, 1, 1, 32'hDEADBEEF, 1};
        apply("ar_pre", v);
        #1 rst = 1'b0;
        #1;
        check("ar_async", '{9, 5, 0, 0, 0, 32'h0, 0, 9, 5, 32'h0, 32'h0, 0, 1, 32'h0, 0});
        @(negedge clk);
        rst = 1'b1;
        apply("ar_after", '{9, 5, 0, 0, 0, 32'h0, 0, 9, 5, 32'h0, 32'h0, 0, 1, 32'h0, 0});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
